// File: rtl/rr_mux_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler: state encoding,
// channel count, reset arbitration pointer and a one-hot helper.
package rr_mux_scheduler_pkg;

  localparam int NUM_CH = 4;
  localparam logic [1:0] RESET_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] sel);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_scheduler_if.sv
// Request/mux/output-stage bundle between the scheduler (master) and the
// producers, the external mux and the downstream consumer (slave).
interface rr_mux_scheduler_if
  import rr_mux_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) ();

  logic [NUM_CH-1:0] req;
  logic [1:0]        mux_sel;
  logic [WIDTH-1:0]  mux_in;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  data_out;
  logic [1:0]        data_ch;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic [CNT_W-1:0]  xfer_count;

  modport master (
    input  req, mux_in, data_ready,
    output mux_sel, grant, data_out, data_ch, data_valid, busy, xfer_count
  );

  modport slave (
    output req, mux_in, data_ready,
    input  mux_sel, grant, data_out, data_ch, data_valid, busy, xfer_count
  );

endinterface

// File: rtl/rr_mux_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set request scanning from the
// channel after the last served one, wrapping back to the last one itself.
module rr_pick4
  import rr_mux_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [1:0]        i_last,
  output logic [1:0]        o_winner,
  output logic              o_any
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_winner = i_last;
    w_found  = 1'b0;
    w_idx    = i_last;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = i_last + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler driving an external 4-to-1 mux and capturing its
// output into a registered valid/ready stage tagged with the source channel.
module rr_mux_scheduler
  import rr_mux_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  rr_mux_scheduler_if.master bus
);

  state_t            r_state;
  logic [1:0]        r_mux_sel;
  logic [1:0]        r_data_ch;
  logic [1:0]        r_last;
  logic [NUM_CH-1:0] r_grant;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_data_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_xfer_count;

  logic [1:0] w_winner;
  logic       w_any;

  rr_pick4 u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // mux_sel only moves on an IDLE win, so mux_in is settled by SAMPLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mux_sel    <= '0;
      r_grant      <= '0;
      r_data_out   <= '0;
      r_data_ch    <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_last       <= RESET_LAST;
      r_xfer_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_grant <= '0;
          if (w_any) begin
            r_mux_sel <= w_winner;
            r_state   <= SAMPLE;
            r_busy    <= 1'b1;
          end
        end
        SAMPLE: begin
          r_data_out   <= bus.mux_in;
          r_data_ch    <= r_mux_sel;
          r_data_valid <= 1'b1;
          r_grant      <= onehot4(r_mux_sel);
          r_state      <= HOLD;
          r_busy       <= 1'b1;
        end
        HOLD: begin
          r_grant <= '0;
          if (bus.data_ready) begin
            r_data_valid <= 1'b0;
            r_last       <= r_data_ch;
            r_xfer_count <= r_xfer_count + CNT_W'(1);
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel    = r_mux_sel;
  assign bus.grant      = r_grant;
  assign bus.data_out   = r_data_out;
  assign bus.data_ch    = r_data_ch;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = r_busy;
  assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Scoreboard bench: stimulus predicts each transfer with a round-robin model
// and queues it; a negedge monitor compares whatever the scheduler presents.
module tb_rr_mux_scheduler;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  rr_mux_scheduler_if #(.WIDTH(4), .CNT_W(16)) bus ();

  rr_mux_scheduler #(.WIDTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0]  muxData [4];
  exp_t        expQ [$];
  logic [1:0]  lastModel;
  logic [15:0] expCount;
  int          doneCount;
  int          readyPct;
  int          checks;
  int          errors;

  assign bus.mux_in = muxData[bus.mux_sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random downstream backpressure, updated away from the sampling edge
  initial begin
    bus.data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.data_ready = ($urandom_range(99, 0) < readyPct);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pickNext(input logic [3:0] reqs, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int c = (int'(last) + k) % 4;
      if (reqs[c]) return 2'(c);
    end
    return last;
  endfunction

  // One transfer: request held for exactly the IDLE sampling edge
  task automatic applyStimulus(input logic [3:0] pattern, input bit randData);
    logic [1:0] w;
    @(negedge clk);
    if (randData)
      for (int i = 0; i < 4; i++) muxData[i] = 4'($urandom_range(15, 0));
    w = pickNext(pattern, lastModel);
    expQ.push_back('{ch: w, data: muxData[w]});
    lastModel = w;
    bus.req = pattern;
    @(posedge clk);
    #1;
    bus.req = '0;
  endtask

  task automatic waitDone(input int target, input int budget, input string name);
    int left;
    left = budget;
    while (doneCount < target && left > 0) begin
      @(negedge clk);
      left--;
    end
    checks++;
    if (doneCount < target) begin
      errors++;
      $display("[TB] FAIL %s: timeout, completed %0d, expected %0d", name, doneCount, target);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    logic prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        prevValid = 1'b0;
        continue;
      end
      checkOutput("xfer_count", 32'(bus.xfer_count), 32'(expCount));
      if (bus.data_valid) begin
        checkOutput("busy_while_valid", 32'(bus.busy), 32'd1);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got ch %0d data %0h, expected no transfer",
                   bus.data_ch, bus.data_out);
        end else begin
          e = expQ[0];
          checkOutput("data_ch", 32'(bus.data_ch), 32'(e.ch));
          checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
          if (!prevValid) checkOutput("grant_pulse", 32'(bus.grant), 32'(4'b0001 << e.ch));
          else            checkOutput("grant_low", 32'(bus.grant), 32'd0);
          if (bus.data_ready) begin
            void'(expQ.pop_front());
            expCount = expCount + 16'd1;
            doneCount++;
          end
        end
      end else begin
        checkOutput("grant_idle", 32'(bus.grant), 32'd0);
      end
      prevValid = bus.data_valid && !bus.data_ready;
    end
  end

  initial begin : stimulus
    int target;
    checks    = 0;
    errors    = 0;
    doneCount = 0;
    expCount  = '0;
    lastModel = 2'd3;
    readyPct  = 100;
    bus.req   = '0;
    for (int i = 0; i < 4; i++) muxData[i] = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_grant", 32'(bus.grant), 32'd0);
    checkOutput("reset_mux_sel", 32'(bus.mux_sel), 32'd0);
    checkOutput("reset_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("reset_data_ch", 32'(bus.data_ch), 32'd0);
    checkOutput("reset_count", 32'(bus.xfer_count), 32'd0);
    #19 rst_n = 1'b1;

    // Idle: no requests, nothing moves
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("idle_valid", 32'(bus.data_valid), 32'd0);
      checkOutput("idle_mux_sel", 32'(bus.mux_sel), 32'd0);
    end

    // All four requesting: expect 0,1,2,3 with fixed mux data
    muxData[0] = 4'h3; muxData[1] = 4'h5; muxData[2] = 4'h9; muxData[3] = 4'hC;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = pickNext(4'b1111, lastModel);
      expQ.push_back('{ch: w, data: muxData[w]});
      lastModel = w;
    end
    bus.req = 4'b1111;
    target = doneCount + 4;
    waitDone(target, 60, "fair_all4");
    bus.req = '0;
    checkOutput("fair_count", 32'(doneCount), 32'd4);

    // Single requester under backpressure, with latency check
    readyPct = 0;
    applyStimulus(4'b0100, 1'b0);
    checkOutput("lat_busy_sample", 32'(bus.busy), 32'd1);
    checkOutput("lat_valid_sample", 32'(bus.data_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid_2cyc", 32'(bus.data_valid), 32'd1);
    repeat (5) @(negedge clk);
    readyPct = 100;
    target = doneCount + 1;
    waitDone(target, 20, "single_ch2");

    // After serving ch1, ch0 must beat ch1
    applyStimulus(4'b0010, 1'b1);
    target = doneCount + 1;
    waitDone(target, 20, "serve_ch1");
    applyStimulus(4'b0011, 1'b1);
    target = doneCount + 1;
    waitDone(target, 20, "rr_after_ch1");

    // Asynchronous reset during the first HOLD cycle
    readyPct = 0;
    applyStimulus(4'b1000, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_valid", 32'(bus.data_valid), 32'd1);
    checkOutput("pre_rst_grant", 32'(bus.grant), 32'b1000);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_count", 32'(bus.xfer_count), 32'd0);
    lastModel = 2'd3;
    expCount  = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    readyPct = 100;
    applyStimulus(4'b1000, 1'b1);
    target = doneCount + 1;
    waitDone(target, 20, "after_rst_ch3");

    // Counter wrap
    @(posedge clk);
    #2;
    force dut.r_xfer_count = 16'hFFFF;
    expCount = 16'hFFFF;
    #1 release dut.r_xfer_count;
    applyStimulus(4'($urandom_range(15, 1)), 1'b1);
    target = doneCount + 1;
    waitDone(target, 20, "wrap_xfer");
    @(negedge clk);
    checkOutput("wrap_count", 32'(bus.xfer_count), 32'd0);

    // Random requests, data and backpressure
    for (int n = 0; n < 40; n++) begin
      readyPct = $urandom_range(100, 20);
      applyStimulus(4'($urandom_range(15, 1)), 1'b1);
      target = doneCount + 1;
      waitDone(target, 400, "random_xfer");
    end

    repeat (4) @(negedge clk);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
